// File: rtl/leddisp_seq_pkg.sv
// Shared types for the debug-channel display sequencer: blank character code
// and the sequencer state encoding.
package leddisp_seq_pkg;

  localparam logic [7:0] CHAR_BLANK = 8'h7f;

  typedef enum logic [1:0] {
    AUTO   = 2'd0,
    MANUAL = 2'd1,
    FROZEN = 2'd2
  } dispseq_state_t;

endpackage

// File: rtl/ledctrl.sv
// Character decoder for one 7-segment digit: codes 0-15 are hex digits, a set of
// ASCII letters is supported, anything else (including 8'h7f) is blank. Active-low {dp,g..a}.
module ledctrl (
  input  logic [7:0] char_code,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'hff;
    case (char_code)
      8'h00: seg = 8'hc0;
      8'h01: seg = 8'hf9;
      8'h02: seg = 8'ha4;
      8'h03: seg = 8'hb0;
      8'h04: seg = 8'h99;
      8'h05: seg = 8'h92;
      8'h06: seg = 8'h82;
      8'h07: seg = 8'hf8;
      8'h08: seg = 8'h80;
      8'h09: seg = 8'h90;
      8'h0a: seg = 8'h88;
      8'h0b: seg = 8'h83;
      8'h0c: seg = 8'hc6;
      8'h0d: seg = 8'ha1;
      8'h0e: seg = 8'h86;
      8'h0f: seg = 8'h8e;
      8'h41, 8'h61: seg = 8'h88;  // A
      8'h42, 8'h62: seg = 8'h83;  // b
      8'h43, 8'h63: seg = 8'hc6;  // C
      8'h44, 8'h64: seg = 8'ha1;  // d
      8'h45, 8'h65: seg = 8'h86;  // E
      8'h46, 8'h66: seg = 8'h8e;  // F
      8'h48, 8'h68: seg = 8'h89;  // H
      8'h4c, 8'h6c: seg = 8'hc7;  // L
      8'h50, 8'h70: seg = 8'h8c;  // P
      8'h53, 8'h73: seg = 8'h92;  // S
      8'h54, 8'h74: seg = 8'h87;  // t
      8'h55, 8'h75: seg = 8'hc1;  // U
      8'h6e:        seg = 8'hab;  // n
      8'h6f:        seg = 8'ha3;  // o
      8'h72:        seg = 8'haf;  // r
      8'h2d:        seg = 8'hbf;  // -
      default:      seg = 8'hff;
    endcase
  end

endmodule

// File: rtl/leddisp_seq.sv
// Multiplexes NCHAN labelled debug channels onto an NDIGITS 7-segment display with
// auto rotation, manual stepping, periodic value snapshots and freeze. Optional LEDDISP_BLINK_EN.
module leddisp_seq
  import leddisp_seq_pkg::*;
#(
  parameter int NDIGITS = 6,
  parameter int LBLW    = 2,
  parameter int VALW    = 16,
  parameter int NCHAN   = 8,
  parameter int DWELL   = 50_000_000,
  parameter int REFRESH = 5_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCHAN*VALW-1:0]     ch_value,
  input  logic [NCHAN*LBLW*8-1:0]   ch_label,
  input  logic [NCHAN-1:0]          ch_wide,
  input  logic                      auto_en,
  input  logic                      step,
  input  logic                      freeze,
  output logic [NDIGITS*8-1:0]      hex,
  output logic [$clog2(NCHAN)-1:0]  cur_chan,
  output logic                      frozen
);

  localparam int CW   = $clog2(NCHAN);
  localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int RW   = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int VD   = NDIGITS - LBLW;
  localparam int NNIB = VALW / 4;
  localparam logic [CW-1:0] CHAN_LAST  = CW'(NCHAN - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [RW-1:0] REFR_LAST  = RW'(REFRESH - 1);

  dispseq_state_t  state_reg, state_next;
  logic [CW-1:0]   chan_reg, chan_next, chan_inc;
  logic [DW-1:0]   dwell_cnt_reg, dwell_cnt_next;
  logic [RW-1:0]   refr_cnt_reg, refr_cnt_next;
  logic [VALW-1:0] snap_reg, snap_next;
  logic            step_q_reg;
  logic            active, chan_adv;
  logic            blank_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= auto_en ? AUTO : MANUAL;
      chan_reg      <= '0;
      dwell_cnt_reg <= '0;
      refr_cnt_reg  <= '0;
      snap_reg      <= '0;
      step_q_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      chan_reg      <= chan_next;
      dwell_cnt_reg <= dwell_cnt_next;
      refr_cnt_reg  <= refr_cnt_next;
      snap_reg      <= snap_next;
      step_q_reg    <= step;
    end
  end

  // Freeze wins over everything in the cycle it is seen, so a coincident
  // dwell wrap or step edge is dropped rather than deferred.
  always_comb begin
    state_next     = freeze ? FROZEN : (auto_en ? AUTO : MANUAL);
    chan_next      = chan_reg;
    dwell_cnt_next = dwell_cnt_reg;
    refr_cnt_next  = refr_cnt_reg;
    snap_next      = snap_reg;
    chan_inc       = (chan_reg == CHAN_LAST) ? '0 : chan_reg + 1'b1;
    active         = !freeze && (state_reg != FROZEN);
    chan_adv       = 1'b0;
    if (active) begin
      if (state_reg == AUTO) begin
        chan_adv       = (dwell_cnt_reg == DWELL_LAST);
        dwell_cnt_next = chan_adv ? '0 : dwell_cnt_reg + 1'b1;
      end else begin
        chan_adv       = step && !step_q_reg;
        dwell_cnt_next = '0;
      end
      if (chan_adv) begin
        chan_next     = chan_inc;
        snap_next     = ch_value[chan_inc*VALW +: VALW];
        refr_cnt_next = '0;
      end else if (refr_cnt_reg == REFR_LAST) begin
        refr_cnt_next = '0;
        snap_next     = ch_value[chan_reg*VALW +: VALW];
      end else begin
        refr_cnt_next = refr_cnt_reg + 1'b1;
      end
    end
  end

`ifdef LEDDISP_BLINK_EN
  // Blink phase runs only while frozen and restarts visible on every freeze.
  logic [RW-1:0] blink_cnt_reg;
  logic          blink_off_reg;

  always_ff @(posedge clk) begin
    if (reset || state_reg != FROZEN) begin
      blink_cnt_reg <= '0;
      blink_off_reg <= 1'b0;
    end else if (blink_cnt_reg == REFR_LAST) begin
      blink_cnt_reg <= '0;
      blink_off_reg <= !blink_off_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  assign blank_val = blink_off_reg;
`else
  assign blank_val = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      logic [7:0] code;
      if (gi >= VD) begin : g_label
        localparam int J = NDIGITS - 1 - gi;
        assign code = ch_label[(chan_reg*LBLW + J)*8 +: 8];
      end else if (gi < NNIB) begin : g_value
        localparam bit NARROW_BLANKED = (gi >= 2);
        always_comb begin
          code = {4'h0, snap_reg[gi*4 +: 4]};
          if (blank_val || (NARROW_BLANKED && !ch_wide[chan_reg]))
            code = CHAR_BLANK;
        end
      end else begin : g_pad
        assign code = CHAR_BLANK;
      end
      ledctrl u_ledctrl (
        .char_code (code),
        .seg       (hex[gi*8 +: 8])
      );
    end
  endgenerate

  assign cur_chan = chan_reg;
  assign frozen   = (state_reg == FROZEN);

endmodule

// File: tb/tb_leddisp_seq.sv
// Randomised scoreboard bench for leddisp_seq: a 16-bit and an 8-bit value build
// share stimulus and are checked every cycle against a behavioural model.
module tb_leddisp_seq;

  localparam int NDIGITS = 6;
  localparam int LBLW    = 2;
  localparam int VALW    = 16;
  localparam int NCHAN   = 4;
  localparam int DWELL   = 4;
  localparam int REFRESH = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NCHAN*VALW-1:0]   ch_value;
  logic [NCHAN*8-1:0]      ch_value8;
  logic [NCHAN*LBLW*8-1:0] ch_label;
  logic [NCHAN-1:0]        ch_wide;
  logic                    auto_en, step, freeze;
  logic [NDIGITS*8-1:0]    hex, hex8;
  logic [1:0]              cur_chan, cur_chan8;
  logic                    frozen, frozen8;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_low
      assign ch_value8[gi*8 +: 8] = ch_value[gi*VALW +: 8];
    end
  endgenerate

  leddisp_seq #(.NDIGITS(NDIGITS), .LBLW(LBLW), .VALW(VALW), .NCHAN(NCHAN),
                .DWELL(DWELL), .REFRESH(REFRESH)) u_dut (
    .clk(clk), .reset(reset), .ch_value(ch_value), .ch_label(ch_label),
    .ch_wide(ch_wide), .auto_en(auto_en), .step(step), .freeze(freeze),
    .hex(hex), .cur_chan(cur_chan), .frozen(frozen));

  leddisp_seq #(.NDIGITS(NDIGITS), .LBLW(LBLW), .VALW(8), .NCHAN(NCHAN),
                .DWELL(DWELL), .REFRESH(REFRESH)) u_dut8 (
    .clk(clk), .reset(reset), .ch_value(ch_value8), .ch_label(ch_label),
    .ch_wide(ch_wide), .auto_en(auto_en), .step(step), .freeze(freeze),
    .hex(hex8), .cur_chan(cur_chan8), .frozen(frozen8));

  typedef struct {
    int          cyc;
    logic [47:0] hex;
    logic [47:0] hex8;
    logic [1:0]  chan;
    logic        frz;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit done  = 0;

  // Behavioural model: mode 0=auto, 1=manual, 2=frozen
  int          m_mode, m_chan, m_dwell, m_refr, m_frzc;
  logic [15:0] m_snap;
  logic        m_stepq;

  function automatic logic [7:0] seg_of(logic [7:0] c);
    case (c)
      8'd0: return 8'hc0;   8'd1: return 8'hf9;   8'd2: return 8'ha4;   8'd3: return 8'hb0;
      8'd4: return 8'h99;   8'd5: return 8'h92;   8'd6: return 8'h82;   8'd7: return 8'hf8;
      8'd8: return 8'h80;   8'd9: return 8'h90;   8'd10: return 8'h88;  8'd11: return 8'h83;
      8'd12: return 8'hc6;  8'd13: return 8'ha1;  8'd14: return 8'h86;  8'd15: return 8'h8e;
      8'h41: return 8'h88;  8'h43: return 8'hc6;  8'h45: return 8'h86;  8'h46: return 8'h8e;
      8'h48: return 8'h89;  8'h4c: return 8'hc7;  8'h50: return 8'h8c;  8'h53: return 8'h92;
      8'h74: return 8'h87;  8'h55: return 8'hc1;  8'h62: return 8'h83;  8'h64: return 8'ha1;
      default: return 8'hff;
    endcase
  endfunction

  function automatic logic [7:0] rand_char();
    logic [7:0] letters [12] = '{8'h41, 8'h43, 8'h45, 8'h46, 8'h48, 8'h4c,
                                 8'h50, 8'h53, 8'h74, 8'h55, 8'h62, 8'h64};
    int r = $urandom_range(0, 29);
    if (r < 16) return 8'(r);
    if (r < 28) return letters[r-16];
    return 8'h7f;
  endfunction

  function automatic logic [47:0] exp_hex(int valw);
    logic [47:0] h;
    logic [7:0]  c;
    bit          blink;
    blink = 0;
`ifdef LEDDISP_BLINK_EN
    blink = (m_mode == 2) && (((m_frzc / REFRESH) % 2) == 1);
`endif
    for (int d = 0; d < NDIGITS; d++) begin
      if (d >= NDIGITS - LBLW)
        c = ch_label[(m_chan*LBLW + (NDIGITS-1-d))*8 +: 8];
      else if (d >= valw/4 || blink || (!ch_wide[m_chan] && d >= 2))
        c = 8'h7f;
      else
        c = {4'h0, m_snap[d*4 +: 4]};
      h[d*8 +: 8] = seg_of(c);
    end
    return h;
  endfunction

  task automatic model_advance();
    bit change;
    if (reset) begin
      m_mode = auto_en ? 0 : 1;
      m_chan = 0; m_dwell = 0; m_refr = 0; m_frzc = 0;
      m_snap = '0; m_stepq = 1'b0;
      return;
    end
    if (m_mode != 2 && !freeze) begin
      change = 0;
      if (m_mode == 0) begin
        m_dwell++;
        if (m_dwell == DWELL) begin m_dwell = 0; change = 1; end
      end else begin
        m_dwell = 0;
        change = step && !m_stepq;
      end
      if (change) begin
        m_chan = (m_chan + 1) % NCHAN;
        m_snap = ch_value[m_chan*VALW +: 16];
        m_refr = 0;
      end else begin
        m_refr++;
        if (m_refr == REFRESH) begin
          m_refr = 0;
          m_snap = ch_value[m_chan*VALW +: 16];
        end
      end
    end
    m_frzc  = (freeze && m_mode == 2) ? m_frzc + 1 : 0;
    m_mode  = freeze ? 2 : (auto_en ? 0 : 1);
    m_stepq = step;
  endtask

  // Inputs for this cycle are already applied; record what the outputs must be.
  task automatic tick();
    exp_t e;
    if (!reset) begin
      e.cyc  = cyc;
      e.hex  = exp_hex(16);
      e.hex8 = exp_hex(8);
      e.chan = 2'(m_chan);
      e.frz  = (m_mode == 2);
      sb.push_back(e);
    end
    model_advance();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string name, int c, logic [47:0] act, logic [47:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("hex16",    e.cyc, hex, e.hex);
        cmp("hex8",     e.cyc, hex8, e.hex8);
        cmp("cur_chan", e.cyc, {46'd0, cur_chan}, {46'd0, e.chan});
        cmp("chan8",    e.cyc, {46'd0, cur_chan8}, {46'd0, e.chan});
        cmp("frozen",   e.cyc, {47'd0, frozen}, {47'd0, e.frz});
        cmp("frozen8",  e.cyc, {47'd0, frozen8}, {47'd0, e.frz});
        $display("cyc %0d chan=%0d frz=%0b hex=%h hex8=%h", e.cyc, cur_chan, frozen, hex, hex8);
      end
    end
  end

  initial begin : stim
    reset = 1'b1; auto_en = 1'b1; step = 1'b0; freeze = 1'b0;
    ch_wide = '1;
    for (int k = 0; k < NCHAN; k++) ch_value[k*VALW +: VALW] = 16'(16'h1111 * k);
    for (int k = 0; k < NCHAN*LBLW; k++) ch_label[k*8 +: 8] = rand_char();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;

    // Auto rotation
    for (int i = 0; i < 24; i++) tick();

    // Manual: five short pulses, then one long hold
    auto_en = 1'b0;
    for (int p = 0; p < 5; p++) begin
      step = 1'b1; tick();
      step = 1'b0; tick(); tick();
    end
    step = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    step = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Refresh: value change on the shown channel only lands on a refresh wrap
    ch_value[m_chan*VALW +: VALW] = 16'hbeef;
    for (int i = 0; i < 4; i++) tick();

    // Freeze coincident with a dwell wrap, value change while frozen, release
    auto_en = 1'b1;
    for (int i = 0; i < 20 && !(m_mode == 0 && m_dwell == DWELL-1); i++) tick();
    freeze = 1'b1; tick();
    ch_value = {$urandom, $urandom};
    for (int i = 0; i < 7; i++) tick();
    freeze = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Narrow channel 2 with label "ST"
    auto_en = 1'b0;
    ch_wide = 4'b1011;
    ch_value[2*VALW +: VALW] = 16'habcd;
    ch_label[(2*LBLW+0)*8 +: 8] = 8'h53;
    ch_label[(2*LBLW+1)*8 +: 8] = 8'h74;
    for (int i = 0; i < 12 && m_chan != 2; i++) begin
      step = 1'b1; tick();
      step = 1'b0; tick();
    end
    for (int i = 0; i < 4; i++) tick();

    // Randomised traffic
    ch_wide = '1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) auto_en = !auto_en;
      if ($urandom_range(0, 24) == 0) freeze = !freeze;
      step = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) ch_value[$urandom_range(0, NCHAN-1)*VALW +: VALW] = 16'($urandom);
      if ($urandom_range(0, 19) == 0) ch_wide = 4'($urandom);
      if ($urandom_range(0, 29) == 0) ch_label[$urandom_range(0, NCHAN*LBLW-1)*8 +: 8] = rand_char();
      tick();
    end

    // Reset in the middle of rotation at channel 3
    freeze = 1'b0; step = 1'b0; auto_en = 1'b1;
    for (int i = 0; i < 40 && m_chan != 3; i++) tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Long freeze (exercises blink when enabled)
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    freeze = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    if (m_mode == 2) begin
      total++; bad++;
      $display("FAIL end_state got=frozen want=running");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
